audio_i2s_tx: RTL
=================

AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

Interface
REQ-001 SHALL have port: Clk  input  1  system clock (50 MHz).
REQ-002 SHALL have port: Reset  input  1  synchronous, active-high reset, sampled on Clk rising edge.
REQ-003 SHALL have port: INIT_FINISH  input  1  codec register configuration complete; 0 holds the block idle.
REQ-004 SHALL have port: Sample  input  16  two's-complement PCM sample from the sample ROM, stable from one data_over pulse until the next.
REQ-005 SHALL have port: AUD_BCLK  input  1  codec bit clock (codec is I2S master), asynchronous to Clk.
REQ-006 SHALL have port: AUD_DACLRCK  input  1  codec DAC word clock (0 = left, 1 = right), asynchronous to Clk.
REQ-007 SHALL have port: AUD_DACDAT  output  1  serial DAC data to the codec.
REQ-008 SHALL have port: data_over  output  1  one-Clk pulse: Sample latched, upstream may advance its address.
REQ-009 SHALL have port: active  output  1  1 while in LEFT or RIGHT state.

Function
REQ-010 SHALL pass AUD_BCLK and AUD_DACLRCK through 2-flop synchronizers plus one history flop each; edge detects are asserted 3 Clk after the pad edge.
REQ-011 SHALL support BCLK half-periods of at least 4 Clk; shorter half-periods are unsupported.
REQ-012 SHALL implement states IDLE, ALIGN, LEFT, RIGHT.
REQ-013 IDLE: AUD_DACDAT = 0; go to ALIGN when INIT_FINISH = 1.
REQ-014 ALIGN: wait for a synchronized DACLRCK falling edge, then go to LEFT; no data is shifted while in ALIGN.
REQ-015 On every DACLRCK falling edge (ALIGN or RIGHT): latch Sample into a 16-bit hold register; pulse data_over for exactly 1 Clk in the same cycle; load the shift register from the hold value; clear the bit counter; enter LEFT.
REQ-016 On every DACLRCK rising edge in LEFT: load the right-channel word (see Configuration); clear the bit counter; enter RIGHT; no data_over pulse.
REQ-017 I2S one-bit delay: the first synchronized BCLK falling edge after a channel load drives the word MSB on AUD_DACDAT; each later falling edge drives the next bit, MSB first.
REQ-018 After 16 bits are driven, AUD_DACDAT SHALL be 0 on all further falling edges until the next DACLRCK edge; the 5-bit bit counter saturates at 16 and does not wrap.
REQ-019 AUD_DACDAT SHALL change only in the Clk cycle a BCLK falling edge (or a channel load) is detected, and SHALL be registered.
REQ-020 If a DACLRCK edge and a BCLK falling edge are detected in the same Clk, the DACLRCK edge has priority; that BCLK edge does not output a bit.
REQ-021 A DACLRCK edge of the wrong polarity for the current state (e.g. falling in LEFT) SHALL resynchronize: falling edge -> REQ-015; rising edge -> REQ-016.
REQ-022 INIT_FINISH dropping to 0 in any state SHALL force IDLE on the next Clk: AUD_DACDAT 0, active 0, no data_over pulse.
REQ-023 Back-to-back frames SHALL produce exactly one data_over pulse per DACLRCK period.

Reset
REQ-024 Reset SHALL force: state IDLE; AUD_DACDAT 0; data_over 0; active 0; hold register, shift register, bit counter, and synchronizer flops all 0.
REQ-025 Reset asserted mid-word SHALL abort the word; after release the block re-enters via ALIGN and sends no partial word.

Configuration
REQ-026 With macro AUDIO_TX_MONO_DUP_EN defined, the right-channel word SHALL equal the latched hold value, so both channels carry the same sample.
REQ-027 Without AUDIO_TX_MONO_DUP_EN, the right-channel word SHALL be 16'h0000, so the right channel is silent.

Verification
REQ-028 Reset held 5 Clk with BCLK toggling -> AUD_DACDAT 0, data_over 0, active 0 throughout.
REQ-029 INIT_FINISH=1, Sample=16'hA5C3, BCLK 3.125 MHz (8 Clk half-period), LRCK = BCLK/64 -> one data_over pulse at the LRCK fall; left bits 1010010111000011 on falling edges 1-16 after the fall; then 0.
REQ-030 Same stimulus, right channel -> 16'hA5C3 with AUDIO_TX_MONO_DUP_EN defined, 16'h0000 without it.
REQ-031 Sample=16'h8001, LRCK fall coinciding with a synchronized BCLK fall -> that edge emits no bit; MSB 1 appears on the next BCLK fall.
REQ-032 INIT_FINISH driven 1 -> 0 at bit 7 of the left word -> AUD_DACDAT 0 and active 0 within 1 Clk; after INIT_FINISH returns to 1, no output until the next LRCK fall.
REQ-033 Run 100 frames -> exactly 100 data_over pulses, each 1 Clk wide.

Source files
------------

// File: rtl/audio_i2s_tx_if.sv
// audio_i2s_tx_if -- sample handshake between the sample ROM side and the
// I2S transmitter.
//   Sample    : two's-complement PCM word, held stable by the upstream
//               side from one data_over pulse to the next.
//   data_over : one-Clk pulse from the transmitter; Sample has been latched
//               and the upstream side may advance to the next word.
// Modports: master = sample source, slave = audio_i2s_tx.
interface audio_i2s_tx_if #(
  parameter int DATA_W = 16
);
  logic signed [DATA_W-1:0] Sample;
  logic                     data_over;

  modport master (output Sample, input data_over);
  modport slave  (input Sample, output data_over);
endinterface

// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx -- I2S DAC serializer running on the 50 MHz system clock,
// slaved to the codec's bit clock and word clock.
//
// Ports:
//   Clk         : system clock
//   Reset       : synchronous, active-high reset
//   INIT_FINISH : codec configuration done; low holds the block idle
//   AUD_BCLK    : codec bit clock (asynchronous to Clk)
//   AUD_DACLRCK : codec word clock, 0 = left, 1 = right (asynchronous)
//   AUD_DACDAT  : registered serial data to the codec
//   active      : high while a left or right word is being framed
//   up          : sample handshake (Sample in, data_over out)
//
// Build option: define AUDIO_TX_MONO_DUP_EN to send the latched sample on
// the right channel too; by default the right channel carries zeros.
//
// Both codec clocks go through two synchronizer flops plus a history flop;
// edges are detected between the second synchronizer flop and the history
// flop, so BCLK half-periods shorter than 4 Clk are not supported.
module audio_i2s_tx #(
  parameter int DATA_W = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               INIT_FINISH,
  input  logic               AUD_BCLK,
  input  logic               AUD_DACLRCK,
  output logic               AUD_DACDAT,
  output logic               active,
  audio_i2s_tx_if.slave      up
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ALIGN = 2'd1;
  localparam logic [1:0] LEFT  = 2'd2;
  localparam logic [1:0] RIGHT = 2'd3;

  localparam logic [4:0] NBITS = 5'(DATA_W);

`ifdef AUDIO_TX_MONO_DUP_EN
  localparam logic [DATA_W-1:0] RIGHT_MASK = '1;
`else
  localparam logic [DATA_W-1:0] RIGHT_MASK = '0;
`endif

  logic [1:0]               state;
  logic                     bclk_p0, bclk_p1, bclk_p2;
  logic                     lrck_p0, lrck_p1, lrck_p2;
  logic signed [DATA_W-1:0] hold;
  logic signed [DATA_W-1:0] shift;
  logic [4:0]               bit_cnt;
  logic                     bclk_fall;
  logic                     lrck_fall;
  logic                     lrck_rise;

  // Right-channel word: the held sample when duplicating, otherwise silence.
  function automatic logic signed [DATA_W-1:0] right_word(
    input logic signed [DATA_W-1:0] h
  );
    return h & RIGHT_MASK;
  endfunction

  // Stage p0/p1: synchronizers; p2: history flop for edge detection.
  assign bclk_fall = bclk_p2 & ~bclk_p1;
  assign lrck_fall = lrck_p2 & ~lrck_p1;
  assign lrck_rise = ~lrck_p2 & lrck_p1;

  assign active = (state == LEFT) || (state == RIGHT);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      bclk_p0       <= 1'b0;
      bclk_p1       <= 1'b0;
      bclk_p2       <= 1'b0;
      lrck_p0       <= 1'b0;
      lrck_p1       <= 1'b0;
      lrck_p2       <= 1'b0;
      state         <= IDLE;
      AUD_DACDAT    <= 1'b0;
      up.data_over  <= 1'b0;
      hold          <= '0;
      shift         <= '0;
      bit_cnt       <= '0;
    end else begin
      bclk_p0      <= AUD_BCLK;
      bclk_p1      <= bclk_p0;
      bclk_p2      <= bclk_p1;
      lrck_p0      <= AUD_DACLRCK;
      lrck_p1      <= lrck_p0;
      lrck_p2      <= lrck_p1;
      up.data_over <= 1'b0;

      if (!INIT_FINISH) begin
        state      <= IDLE;
        AUD_DACDAT <= 1'b0;
        bit_cnt    <= '0;
      end else if (state == IDLE) begin
        state      <= ALIGN;
        AUD_DACDAT <= 1'b0;
      end else if (lrck_fall) begin
        // Start of a frame, from ALIGN or as a resync from LEFT/RIGHT.
        // The word clock wins over a coincident BCLK edge, which is what
        // gives the I2S one-bit delay before the MSB.
        hold         <= up.Sample;
        shift        <= up.Sample;
        up.data_over <= 1'b1;
        bit_cnt      <= '0;
        AUD_DACDAT   <= 1'b0;
        state        <= LEFT;
      end else if (lrck_rise && state != ALIGN) begin
        shift      <= right_word(hold);
        bit_cnt    <= '0;
        AUD_DACDAT <= 1'b0;
        state      <= RIGHT;
      end else if (bclk_fall && state != ALIGN) begin
        // Bit counter stops at the word length; trailing slots send zero.
        if (bit_cnt < NBITS) begin
          AUD_DACDAT <= shift[DATA_W-1];
          shift      <= {shift[DATA_W-2:0], 1'b0};
          bit_cnt    <= bit_cnt + 5'd1;
        end else begin
          AUD_DACDAT <= 1'b0;
        end
      end
    end
  end

endmodule
